// File: rtl/filter_pkg.sv
// Shared types for the filter mode scheduler: filter modes, scheduler FSM states,
// window geometry and the debug bundle exposed by the top.
package filter_pkg;

  typedef enum logic [2:0] {
    FM_RAW     = 3'd0,
    FM_INVERT  = 3'd1,
    FM_GAUSS   = 3'd2,
    FM_SOBEL   = 3'd3,
    FM_SEPIA   = 3'd4,
    FM_EMBOSS  = 3'd5,
    FM_SHARPEN = 3'd6,
    FM_SOLAR   = 3'd7
  } filter_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } filter_state_e;

  localparam int FILTER_WIN = 3;
  // A 3x3 window needs two earlier rows/columns before its output is meaningful.
  localparam int WIN_PRIME  = FILTER_WIN - 1;

  typedef struct packed {
    filter_state_e state;
    logic [2:0]    sw_rise;
    logic          btn_rise;
  } sched_dbg_t;

  function automatic logic is_spatial(filter_mode_e m);
    return (m == FM_GAUSS) || (m == FM_SOBEL) || (m == FM_EMBOSS) || (m == FM_SHARPEN);
  endfunction

endpackage

// File: rtl/filter_mode_scheduler_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous level, plus a rising-edge pulse
// derived from the synchronized value.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic q_sync,
  output logic q_rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d_async};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q_sync = chain[SYNC_STAGES-1];
  assign q_rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/filter_mode_scheduler.sv
// Chooses the active filter mode (manual switches or auto-cycle), applies changes only
// at frame boundaries, and qualifies each filtered pixel against the window priming region.
module filter_mode_scheduler
  import filter_pkg::*;
#(
  parameter int FRAME_W     = 320,
  parameter int FRAME_H     = 240,
  parameter int AUTO_FRAMES = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sw,
  input  logic             btn_next,
  input  logic             auto_en,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [9:0]       x_pixel,
  input  logic [9:0]       y_pixel,
  output logic [2:0]       filter_sel,
  output logic             pending,
  output logic             mode_changed,
  output logic             window_valid,
  output logic [7:0]       auto_cnt,
  output sched_dbg_t       dbg
);

  localparam logic [7:0] CNT_LAST  = 8'(AUTO_FRAMES - 1);
  localparam logic [9:0] X_LIM     = 10'(FRAME_W);
  localparam logic [9:0] Y_LIM     = 10'(FRAME_H);
  localparam logic [9:0] PRIME_LIM = 10'(WIN_PRIME);

  logic [2:0]    sw_sync;
  logic [2:0]    sw_rise;
  logic          btn_sync;
  logic          btn_rise;
  filter_mode_e  target;
  filter_mode_e  sel_q;
  logic [7:0]    cnt_q;
  filter_state_e state_q;
  filter_state_e state_d;
  logic          wv_q;

  for (genvar i = 0; i < 3; i++) begin : g_sw_sync
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sw (
      .clk     (clk),
      .reset   (reset),
      .d_async (sw[i]),
      .q_sync  (sw_sync[i]),
      .q_rise  (sw_rise[i])
    );
  end

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
    .clk     (clk),
    .reset   (reset),
    .d_async (btn_next),
    .q_sync  (btn_sync),
    .q_rise  (btn_rise)
  );

  // A button press coinciding with the period rollover still advances by only one mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target <= FM_RAW;
      cnt_q  <= 8'd0;
    end else if (!auto_en) begin
      target <= filter_mode_e'(sw_sync);
      cnt_q  <= 8'd0;
    end else if (btn_rise || (frame_start && (cnt_q == CNT_LAST))) begin
      target <= filter_mode_e'(target + 3'd1);
      cnt_q  <= 8'd0;
    end else if (frame_start) begin
      cnt_q  <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (target != sel_q) state_d = ST_PEND;
      ST_PEND: begin
        if (target == sel_q)  state_d = ST_IDLE;
        else if (frame_start) state_d = ST_APPLY;
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pending      = (state_q == ST_PEND);
    mode_changed = (state_q == ST_APPLY);
  end

  // The mode only moves on the edge closing a frame_start cycle, so no frame is split.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_q <= FM_RAW;
    else if ((state_q == ST_PEND) && frame_start && (target != sel_q)) sel_q <= target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wv_q <= 1'b0;
    end else begin
      wv_q <= pix_valid && (x_pixel < X_LIM) && (y_pixel < Y_LIM) &&
              (!is_spatial(sel_q) || ((x_pixel >= PRIME_LIM) && (y_pixel >= PRIME_LIM)));
    end
  end

  assign filter_sel   = sel_q;
  assign auto_cnt     = cnt_q;
  assign window_valid = wv_q;
  assign dbg          = '{state: state_q, sw_rise: sw_rise, btn_rise: btn_rise};

  logic unused_ok;
  assign unused_ok = btn_sync;

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// Directed bench for filter_mode_scheduler: a cycle-level behavioural model checked
// every cycle, plus hand-computed expectations for the scenario milestones.
module tb_filter_mode_scheduler;

  localparam int FRAME_W     = 320;
  localparam int FRAME_H     = 240;
  localparam int AUTO_FRAMES = 2;
  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic       btn_next;
  logic       auto_en;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic [2:0] filter_sel;
  logic       pending;
  logic       mode_changed;
  logic       window_valid;
  logic [7:0] auto_cnt;
  logic [5:0] dbg;

  int checks = 0;
  int errors = 0;
  int cyc;
  int mc_count;

  filter_mode_scheduler #(
    .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .AUTO_FRAMES(AUTO_FRAMES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .sw           (sw),
    .btn_next     (btn_next),
    .auto_en      (auto_en),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .x_pixel      (x_pixel),
    .y_pixel      (y_pixel),
    .filter_sel   (filter_sel),
    .pending      (pending),
    .mode_changed (mode_changed),
    .window_valid (window_valid),
    .auto_cnt     (auto_cnt),
    .dbg          (dbg)
  );

  // ---------------- clock / reset bookkeeping ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mc_count <= 0;
    else if (mode_changed) mc_count <= mc_count + 1;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pending(k) = mode differs at k-1 and no pulse at k or k-1;
  // pulse(k)   = pending at k-1 with frame_start and a difference.
  logic [2:0] swd [SYNC_STAGES];
  logic       btd [SYNC_STAGES];
  logic       m_bprev;
  int         m_target, m_sel, m_cnt;
  logic       m_pend, m_mc, m_wv;

  function automatic bit spatial(input int m);
    return (m == 2) || (m == 3) || (m == 5) || (m == 6);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [2:0] ss;
    logic       bs, br, diff, mc, pd;
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        swd[i] = '0;
        btd[i] = 1'b0;
      end
      m_bprev = 0; m_target = 0; m_sel = 0; m_cnt = 0;
      m_pend = 0; m_mc = 0; m_wv = 0;
    end else begin
      ss   = swd[SYNC_STAGES-1];
      bs   = btd[SYNC_STAGES-1];
      br   = bs & ~m_bprev;
      diff = (m_target != m_sel);
      mc   = m_pend && frame_start && diff;
      pd   = diff && !mc && !m_mc;
      m_wv = pix_valid && (int'(x_pixel) < FRAME_W) && (int'(y_pixel) < FRAME_H) &&
             (!spatial(m_sel) || ((x_pixel >= 2) && (y_pixel >= 2)));
      if (mc) m_sel = m_target;
      m_mc   = mc;
      m_pend = pd;
      if (!auto_en) begin
        m_target = int'(ss);
        m_cnt    = 0;
      end else if (br || (frame_start && m_cnt == AUTO_FRAMES - 1)) begin
        m_target = (m_target + 1) % 8;
        m_cnt    = 0;
      end else if (frame_start) begin
        m_cnt = m_cnt + 1;
      end
      m_bprev = bs;
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        swd[i] = swd[i-1];
        btd[i] = btd[i-1];
      end
      swd[0] = sw;
      btd[0] = btn_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("filter_sel",   int'(filter_sel),   m_sel);
    check("pending",      int'(pending),      int'(m_pend));
    check("mode_changed", int'(mode_changed), int'(m_mc));
    check("window_valid", int'(window_valid), int'(m_wv));
    check("auto_cnt",     int'(auto_cnt),     m_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input int exp_wv, input string name);
    pix_valid = 1'b1;
    x_pixel   = 10'(x);
    y_pixel   = 10'(y);
    @(negedge clk);
    pix_valid = 1'b0;
    check(name, int'(window_valid), exp_wv);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int mc_base;
    rst_n = 1'b0; sw = '0; btn_next = 1'b0; auto_en = 1'b0;
    frame_start = 1'b0; pix_valid = 1'b0; x_pixel = '0; y_pixel = '0;
    tick(3);
    check("rst_filter_sel", int'(filter_sel), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_auto_cnt", int'(auto_cnt), 0);
    rst_n = 1'b1;

    // Manual change with fixed latency
    wait_cyc(10); sw = 3'd3;
    wait_cyc(13); check("t1_pending_c13", int'(pending), 0);
    wait_cyc(14); check("t1_pending_c14", int'(pending), 1);
    check("t1_sel_before", int'(filter_sel), 0);
    wait_cyc(40); frame_start = 1'b1;
    wait_cyc(41); frame_start = 1'b0;
    check("t1_sel_c41", int'(filter_sel), 3);
    check("t1_mc_c41", int'(mode_changed), 1);
    check("t1_pending_c41", int'(pending), 0);
    wait_cyc(42); check("t1_mc_c42", int'(mode_changed), 0);

    // Retract inside one frame
    sw = 3'd0; tick(6); frame(); tick(2);
    check("t2_sel_zero", int'(filter_sel), 0);
    mc_base = mc_count;
    sw = 3'd5; tick(5);
    check("t2_pending_up", int'(pending), 1);
    sw = 3'd0; tick(5);
    check("t2_pending_down", int'(pending), 0);
    check("t2_sel_kept", int'(filter_sel), 0);
    check("t2_no_pulse", mc_count, mc_base);

    // Auto wrap 7 -> 0
    sw = 3'd7; tick(5); frame(); tick(2);
    check("t3_sel7", int'(filter_sel), 7);
    auto_en = 1'b1; tick(2);
    frame(); tick(1);
    check("t3_cnt1", int'(auto_cnt), 1);
    tick(2); frame();
    check("t3_cnt0", int'(auto_cnt), 0);
    check("t3_sel_still7", int'(filter_sel), 7);
    tick(3); frame();
    check("t3_sel_wrap0", int'(filter_sel), 0);
    check("t3_cnt_after", int'(auto_cnt), 1);

    // Button coincident with rollover frame_start: one step only
    btn_next = 1'b1; tick(2); frame();
    check("t4_cnt0", int'(auto_cnt), 0);
    tick(3);
    check("t4_pending", int'(pending), 1);
    frame();
    check("t4_sel_plus1", int'(filter_sel), 1);
    btn_next = 1'b0; tick(3);

    // Window gate for spatial and point modes
    auto_en = 1'b0; sw = 3'd3; tick(5); frame(); tick(2);
    check("t5_sel_sobel", int'(filter_sel), 3);
    pixel(1, 5, 0, "t5_sobel_1_5");
    pixel(2, 1, 0, "t5_sobel_2_1");
    pixel(2, 2, 1, "t5_sobel_2_2");
    pixel(319, 239, 1, "t5_sobel_319_239");
    pixel(320, 10, 0, "t5_sobel_x_out");
    sw = 3'd1; tick(5); frame(); tick(2);
    check("t5_sel_invert", int'(filter_sel), 1);
    pixel(1, 5, 1, "t5_inv_1_5");
    pixel(2, 1, 1, "t5_inv_2_1");
    pixel(2, 2, 1, "t5_inv_2_2");
    pixel(319, 239, 1, "t5_inv_319_239");
    pixel(5, 240, 0, "t5_inv_y_out");

    // Reset while pending
    sw = 3'd6; tick(5);
    check("t6_pending", int'(pending), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_sel", int'(filter_sel), 0);
    check("t6_rst_pending", int'(pending), 0);
    check("t6_rst_mc", int'(mode_changed), 0);
    check("t6_rst_wv", int'(window_valid), 0);
    check("t6_rst_cnt", int'(auto_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(6); frame();
    check("t6_sel_after", int'(filter_sel), 6);
    check("t6_mc_after", int'(mode_changed), 1);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
